// File: rtl/tdc_readout.sv
// tdc_readout: measurement controller and thermometer decoder for the
// inverter-chain TDC delay line. Fires a programmable-width start pulse,
// synchronizes and decodes the captured snapshot, and accumulates
// 2^LOG2_AVG samples per burst. Results go out on a valid/ready handshake.
module tdc_readout #(
  parameter int N_DELAY  = 32,
  parameter int LOG2_AVG = 2,
  parameter int SETTLE   = 4,
  localparam int W       = $clog2(N_DELAY + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    meas_req,
  input  logic [7:0]              pulse_len,
  output logic                    start,
  input  logic [N_DELAY-1:0]      time_count,
  output logic                    busy,
  output logic [W+LOG2_AVG-1:0]   result_sum,
  output logic [W-1:0]            result_avg,
  output logic                    bubble_err,
  output logic                    sat,
  output logic                    result_valid,
  input  logic                    result_ready
);

  localparam int AW = W + LOG2_AVG;
  localparam int CW = LOG2_AVG + 1;
  localparam int TW = ($clog2(SETTLE) > 8) ? $clog2(SETTLE) : 8;
  localparam logic [CW-1:0] LAST_SAMPLE = CW'((1 << LOG2_AVG) - 1);

  typedef enum logic [2:0] {
    IDLE,
    PULSE,
    SETTLE_WAIT,
    SAMPLE,
    DONE
  } state_t;

  state_t              state;
  logic [N_DELAY-1:0]  sync1;
  logic [N_DELAY-1:0]  sync2;
  logic [7:0]          len_q;
  logic [7:0]          len_eff;
  logic [TW-1:0]       timer;
  logic [CW-1:0]       smp_cnt;
  logic [W-1:0]        pop;
  logic                bub_c;
  logic                sat_c;

  // Two-flop synchronizer for the asynchronous thermometer snapshot
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= time_count;
      sync2 <= sync1;
    end
  end

  // Decode the synchronized snapshot: popcount, bubble and saturation flags
  always_comb begin
    pop   = '0;
    bub_c = 1'b0;
    for (int unsigned i = 0; i < N_DELAY; i++) begin
      pop = pop + W'(sync2[i]);
    end
    for (int unsigned i = 1; i < N_DELAY; i++) begin
      if (sync2[i] && !sync2[i-1]) bub_c = 1'b1;
    end
    sat_c = &sync2;
  end

  // A requested pulse length of zero is stretched to one cycle
  always_comb begin
    len_eff = (pulse_len == 8'd0) ? 8'd1 : pulse_len;
  end

  // Measurement FSM with registered outputs and accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      start        <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_sum   <= '0;
      bubble_err   <= 1'b0;
      sat          <= 1'b0;
      len_q        <= 8'd1;
      timer        <= '0;
      smp_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (meas_req) begin
            len_q      <= len_eff;
            timer      <= TW'(len_eff - 8'd1);
            result_sum <= '0;
            bubble_err <= 1'b0;
            sat        <= 1'b0;
            smp_cnt    <= '0;
            start      <= 1'b1;
            busy       <= 1'b1;
            state      <= PULSE;
          end
        end
        PULSE: begin
          if (timer == '0) begin
            start <= 1'b0;
            timer <= TW'(SETTLE - 1);
            state <= SETTLE_WAIT;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        SETTLE_WAIT: begin
          if (timer == '0) begin
            state <= SAMPLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        SAMPLE: begin
          result_sum <= result_sum + AW'(pop);
          bubble_err <= bubble_err | bub_c;
          sat        <= sat | sat_c;
          smp_cnt    <= smp_cnt + CW'(1);
          if (smp_cnt == LAST_SAMPLE) begin
            result_valid <= 1'b1;
            state        <= DONE;
          end else begin
            // Next pulse starts on this same edge so each period is L+SETTLE+1
            start <= 1'b1;
            timer <= TW'(len_q - 8'd1);
            state <= PULSE;
          end
        end
        DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Average is the floor of the sum over the sample count
  assign result_avg = W'(result_sum >> LOG2_AVG);

endmodule

// File: tb/tb_tdc_readout.sv
// tb_tdc_readout: directed bursts against a delay-line model; expected
// results are queued at request time and checked by an independent monitor.
module tb_tdc_readout;

  localparam int N_DELAY  = 32;
  localparam int LOG2_AVG = 2;
  localparam int SETTLE   = 4;
  localparam int W        = 6;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  meas_req;
  logic [7:0]            pulse_len;
  logic                  start;
  logic [N_DELAY-1:0]    time_count;
  logic                  busy;
  logic [W+LOG2_AVG-1:0] result_sum;
  logic [W-1:0]          result_avg;
  logic                  bubble_err;
  logic                  sat;
  logic                  result_valid;
  logic                  result_ready;

  tdc_readout #(
    .N_DELAY (N_DELAY),
    .LOG2_AVG(LOG2_AVG),
    .SETTLE  (SETTLE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .meas_req    (meas_req),
    .pulse_len   (pulse_len),
    .start       (start),
    .time_count  (time_count),
    .busy        (busy),
    .result_sum  (result_sum),
    .result_avg  (result_avg),
    .bubble_err  (bubble_err),
    .sat         (sat),
    .result_valid(result_valid),
    .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   sum;
    int   avg;
    logic bub;
    logic sat;
    int   vcyc;
  } exp_t;

  exp_t               sb[$];
  int                 n_checks = 0;
  int                 n_fail   = 0;
  int                 cyc      = 0;
  int                 exp_l    = 1;
  logic [N_DELAY-1:0] samp[4];
  int                 sidx     = 4;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Delay-line model: each falling edge of start captures the next snapshot
  always @(negedge start) begin
    if (sidx < 4) begin
      time_count = samp[sidx];
      sidx++;
    end
  end

  // Monitor: pulse widths, pulse count, and scoreboard pop on result_valid rise
  int   hi_cnt = 0;
  int   pulses = 0;
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      hi_cnt     = 0;
      pulses     = 0;
      prev_valid = 1'b0;
    end else begin
      if (start) begin
        hi_cnt++;
      end else if (hi_cnt > 0) begin
        check("pulse_width", hi_cnt, exp_l);
        pulses++;
        hi_cnt = 0;
      end
      if (result_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result_sum", result_sum, e.sum);
          check("result_avg", result_avg, e.avg);
          check("bubble_err", bubble_err, e.bub);
          check("sat", sat, e.sat);
          check("valid_cycle", cyc, e.vcyc);
          check("pulse_count", pulses, 4);
        end
        pulses = 0;
      end
      prev_valid = result_valid;
    end
  end

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic run_burst(input logic [7:0] l, input logic [31:0] s0, input logic [31:0] s1,
                           input logic [31:0] s2, input logic [31:0] s3, input int esum,
                           input int eavg, input logic ebub, input logic esat, input int hold);
    exp_t e;
    int   t;
    logic [W+LOG2_AVG-1:0] hs;
    logic [W-1:0] ha;
    logic hb, hsat;
    samp[0] = s0; samp[1] = s1; samp[2] = s2; samp[3] = s3;
    sidx = 0;
    exp_l = (l == 8'd0) ? 1 : int'(l);
    result_ready = 1'b0;
    pulse_len = l;
    meas_req = 1'b1;
    @(posedge clk);
    #1;
    meas_req = 1'b0;
    pulse_len = 8'd200;
    e.sum = esum; e.avg = eavg; e.bub = ebub; e.sat = esat;
    e.vcyc = cyc + 4 * (exp_l + SETTLE + 1);
    sb.push_back(e);
    @(negedge clk);
    check("accept_busy", busy, 1);
    check("accept_start", start, 1);
    t = 0;
    while (!result_valid && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!result_valid) begin
      check("result_valid_timeout", 0, 1);
      finish_run();
    end
    if (hold > 0) begin
      hs = result_sum; ha = result_avg; hb = bubble_err; hsat = sat;
      meas_req = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_valid", result_valid, 1);
        check("hold_start", start, 0);
        check("hold_sum", result_sum, hs);
        check("hold_avg", result_avg, ha);
        check("hold_flags", {bubble_err, sat}, {hb, hsat});
      end
    end
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    if (hold == 0) meas_req = 1'b0;
    @(negedge clk);
    check("idle_after_handshake", {busy, result_valid}, 0);
  endtask

  initial begin
    rst = 1'b1;
    meas_req = 1'b0;
    pulse_len = 8'd0;
    time_count = '0;
    result_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_start", start, 0);
    check("reset_busy", busy, 0);
    check("reset_valid", result_valid, 0);
    check("reset_sum", result_sum, 0);
    check("reset_avg", result_avg, 0);
    check("reset_flags", {bubble_err, sat}, 0);
    #1 rst = 1'b0;

    // Reset during PULSE with L=5
    exp_l = 5;
    pulse_len = 8'd5;
    meas_req = 1'b1;
    @(posedge clk);
    #1 meas_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("pre_reset_start", start, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midreset_start", start, 0);
    check("midreset_busy", busy, 0);
    check("midreset_valid", result_valid, 0);
    check("midreset_flags", {bubble_err, sat}, 0);
    repeat (3) @(negedge clk);
    check("midreset_stays_idle", {busy, start}, 0);

    // Constant 0xFF samples: 8 ones each
    run_burst(8'd5, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FF, 32, 8, 1'b0, 1'b0, 0);
    // Varying: 3,4,5,6 ones
    run_burst(8'd5, 32'h0000_0007, 32'h0000_000F, 32'h0000_001F, 32'h0000_003F, 18, 4, 1'b0, 1'b0, 0);
    // Bubble in one sample: 7+4+4+4
    run_burst(8'd5, 32'h0000_00F7, 32'h0000_000F, 32'h0000_000F, 32'h0000_000F, 19, 4, 1'b1, 1'b0, 0);
    // Saturated then empty
    run_burst(8'd5, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32, 8, 1'b0, 1'b1, 0);
    // pulse_len=0 with 10 cycles of backpressure and meas_req held high
    run_burst(8'd0, 32'h0000_0003, 32'h0000_0003, 32'h0000_0003, 32'h0000_0003, 8, 2, 1'b0, 1'b0, 10);
    // Back-to-back burst accepted on the first IDLE edge
    run_burst(8'd0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 4, 1, 1'b0, 1'b0, 0);
    // Longer pulse, odd sum to exercise floor in the average
    run_burst(8'd3, 32'h0000_0001, 32'h0000_0003, 32'h0000_0007, 32'h0000_0007, 9, 2, 1'b0, 1'b0, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    finish_run();
  end

  // Global guard so the run always terminates
  initial begin
    #200000;
    check("global_timeout", 0, 1);
    finish_run();
  end

endmodule

// File: doc/tdc_readout.md
# tdc_readout

Measurement controller and decoder for the inverter-chain TDC delay line. Drives the line's `start` input with a programmable-width pulse; the falling edge of that pulse captures the line. The block then takes the line's `time_count` thermometer snapshot into the clock domain, decodes it to a binary count, and accumulates 2^LOG2_AVG samples per measurement. The summed and averaged results go to the host side through a valid/ready handshake.

## Interface
Parameters:
- `N_DELAY`, default 32: thermometer width. Must equal the delay line's `N_DELAY`.
- `LOG2_AVG`, default 2: the block takes 2^LOG2_AVG samples per measurement.
- `SETTLE`, default 4: cycles `start` is held low before each sample. Minimum 3.
- Derived: `W = $clog2(N_DELAY+1)`, which is 6 at the default `N_DELAY`.

Ports:
- `clk`, in, 1: system clock. This is the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `meas_req`, in, 1: request for a measurement burst. It is sampled only in IDLE.
- `pulse_len`, in, 8: high time of `start` in clk cycles. A value of 0 is treated as 1. Latched on acceptance.
- `start`, out, 1: driven from a flop to the delay line's `start`.
- `time_count`, in, N_DELAY: thermometer snapshot from the delay line. Asynchronous to `clk`.
- `busy`, out, 1: high in every state except IDLE.
- `result_sum`, out, W+LOG2_AVG: sum of the sample counts.
- `result_avg`, out, W: `result_sum >> LOG2_AVG`, floor.
- `bubble_err`, out, 1: set if any sample in the burst was not a clean thermometer code.
- `sat`, out, 1: set if any sample in the burst was all ones (the edge ran past the end of the line).
- `result_valid`, out, 1: result outputs are valid.
- `result_ready`, in, 1: consumer accepts the result.

## Operation
- `time_count` passes through a 2-flop synchronizer. Only the second stage is used.
- Decode rules for a synchronized snapshot `s`:
  - Count = popcount(`s`), range 0..N_DELAY. Using popcount makes the count tolerant of bubbles.
  - Bubble condition: some i with `s[i]`=1 and `s[i-1]`=0, for i = 1..N_DELAY-1. In words, `s` is not of the form 0…01…1.
  - Saturation condition: `s` is all ones.
- FSM states are IDLE, PULSE, SETTLE, SAMPLE and DONE.
  - IDLE: `start`=0.
    - If `meas_req`=1, latch `max(pulse_len,1)` as L.
    - Clear the accumulator, `bubble_err`, `sat` and the sample counter.
    - Go to PULSE.
  - PULSE: `start`=1 for exactly L cycles, then go to SETTLE.
  - SETTLE: `start`=0 for SETTLE cycles, then go to SAMPLE.
  - SAMPLE: one cycle.
    - Add the count to the accumulator.
    - OR the bubble condition into `bubble_err` and the saturation condition into `sat`.
    - Increment the sample counter.
    - After sample 2^LOG2_AVG, go to DONE. Otherwise go to PULSE.
  - DONE: `result_valid`=1 and `start`=0.
    - On `result_valid && result_ready`, go to IDLE on the next edge.
- Accumulator width is W+LOG2_AVG. It cannot overflow, since the maximum sum is N_DELAY·2^LOG2_AVG.
- `meas_req` is ignored outside IDLE; the block does not queue requests.
- `pulse_len` changes after acceptance have no effect on the current burst.

## Timing
- Reset values: `start`=0, `busy`=0, `result_valid`=0, `result_sum`=0, `result_avg`=0, `bubble_err`=0, `sat`=0, FSM in IDLE, synchronizer flops cleared.
- Reset in any state, including mid-pulse, forces the reset values at the next edge. The partial burst is discarded and no result is produced.
- Let E0 be the edge that accepts `meas_req`.
  - `start` rises at E0 and falls at E0+L.
  - Each sample period is L+SETTLE+1 cycles.
  - `result_valid` rises at E0 + 2^LOG2_AVG·(L+SETTLE+1).
- `start` is low for at least SETTLE cycles between pulses.
- The snapshot sampled in SAMPLE was captured by the delay line at least SETTLE−2 ≥ 1 cycles before it leaves the synchronizer.
- Result outputs are stable while `result_valid`=1 and `result_ready`=0.
- `busy` falls on the edge after the handshake.
- Back-to-back bursts:
  - If `meas_req` is already high on the first IDLE cycle after the handshake, the new burst is accepted on that edge.
  - The minimum gap from handshake to the next `start` rise is 1 cycle.

## Test plan
- Reset mid-burst:
  - Stimulus: assert `rst` during PULSE with L=5.
  - Required: `start`, `busy`, `result_valid`, `bubble_err` and `sat` are 0 at the next edge.
  - Required: a new request then completes normally.
- Constant sample (delay-line model returns `0x000000FF`, L=5, LOG2_AVG=2):
  - Required: `start` pulses 4 times, each 5 cycles high.
  - Required: `result_sum`=32, `result_avg`=8, `bubble_err`=0, `sat`=0.
  - Required: `result_valid` rises at E0+40.
- Varying samples (model returns 3, 4, 5 and 6 ones in sequence):
  - Required: `result_sum`=18, `result_avg`=4.
- Bubble sample (one sample is `0x000000F7`, the rest are `0x0000000F`):
  - Required: `result_sum`=7+4+4+4=19, `bubble_err`=1, `sat`=0.
- Saturation and empty (samples are `0xFFFFFFFF`, 0, 0, 0):
  - Required: `result_sum`=32, `result_avg`=8, `sat`=1, `bubble_err`=0.
- Backpressure and pulse_len=0:
  - Stimulus: hold `result_ready`=0 for 10 cycles with `meas_req` high.
  - Required: outputs stay stable and `start` stays 0.
  - Stimulus: raise `result_ready`.
  - Required: IDLE follows, and the next burst is accepted.
  - Required: with `pulse_len`=0, `start` is high for exactly 1 cycle per sample.
